// File: rtl/wb_pkg.sv
// Shared constants and writeback port indices for the register-file scoreboard.
// The optional forwarding build is selected with WB_FORWARD_EN (see wb_scoreboard_ctrl).
package wb_pkg;
   localparam int NREGS = 16;
   localparam int AW    = 4;
   localparam int DW    = 16;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wbPort_e;
endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin arbiter. prioQ names the port that wins the next tie;
// it moves to the other port whenever a grant is issued.
module wb_rr_arb2
   import wb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   wbPort_e prioQ;

   always_comb begin
      gnt = 2'b00;
      if (req[0] && req[1])
         gnt = (prioQ == WB_ALU) ? 2'b01 : 2'b10;
      else
         gnt = req;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         prioQ <= WB_ALU;
      else if (gnt[0])
         prioQ <= WB_MEM;
      else if (gnt[1])
         prioQ <= WB_ALU;
   end

endmodule

// File: rtl/wb_scoreboard_ctrl.sv
// Register hazard scoreboard plus single-port writeback stage fed by a 2-way arbiter.
// Define WB_FORWARD_EN to mask the in-flight write from the stall check and expose fwd1/fwd2.
module wb_scoreboard_ctrl
   import wb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             iss_valid,
   input  logic [AW-1:0]    iss_src1,
   input  logic [AW-1:0]    iss_src2,
   input  logic             iss_has_dest,
   input  logic [AW-1:0]    iss_dest,
   output logic             iss_stall,
   input  logic             wb0_valid,
   input  logic [AW-1:0]    wb0_addr,
   input  logic [DW-1:0]    wb0_data,
   output logic             wb0_ready,
   input  logic             wb1_valid,
   input  logic [AW-1:0]    wb1_addr,
   input  logic [DW-1:0]    wb1_data,
   output logic             wb1_ready,
   output logic             wr_en,
   output logic [AW-1:0]    wr_addr,
   output logic [DW-1:0]    wr_data,
   output logic [NREGS-1:0] busy_vec,
`ifdef WB_FORWARD_EN
   output logic             fwd1,
   output logic             fwd2,
`endif
   output logic             err_spurious
);

   logic [NREGS-1:0] busyQ, busyChk, setVec, clrVec;
   logic [1:0]       gnt;
   logic             wrEnQ, errQ;
   logic [AW-1:0]    wrAddrQ;
   logic [DW-1:0]    wrDataQ;
   logic             issFire, xferAny;
   logic [AW-1:0]    xferAddr;
   logic [DW-1:0]    xferData;

   wb_rr_arb2 uArb (
      .clk (clk),
      .rst (rst),
      .req ({wb1_valid, wb0_valid}),
      .gnt (gnt)
   );

   assign wb0_ready = gnt[WB_ALU];
   assign wb1_ready = gnt[WB_MEM];
   assign xferAny   = |gnt;
   assign xferAddr  = gnt[WB_MEM] ? wb1_addr : wb0_addr;
   assign xferData  = gnt[WB_MEM] ? wb1_data : wb0_data;

   // The register being written this cycle is readable via the bypass, so it
   // no longer blocks decode when forwarding is built in.
   always_comb begin
      busyChk = busyQ;
`ifdef WB_FORWARD_EN
      if (wrEnQ)
         busyChk[wrAddrQ] = 1'b0;
`endif
   end

   assign iss_stall = iss_valid & (busyChk[iss_src1] | busyChk[iss_src2] |
                                   (iss_has_dest & busyChk[iss_dest]));
   assign issFire   = iss_valid & ~iss_stall;

   always_comb begin
      setVec = '0;
      clrVec = '0;
      if (issFire && iss_has_dest)
         setVec[iss_dest] = 1'b1;
      if (wrEnQ)
         clrVec[wrAddrQ] = 1'b1;
   end

   // Set after clear: a newly issued producer keeps ownership of the register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         busyQ <= '0;
      else
         busyQ <= (busyQ & ~clrVec) | setVec;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrEnQ   <= 1'b0;
         wrAddrQ <= '0;
         wrDataQ <= '0;
      end else begin
         wrEnQ <= xferAny;
         if (xferAny) begin
            wrAddrQ <= xferAddr;
            wrDataQ <= xferData;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         errQ <= 1'b0;
      else if (xferAny && !busyQ[xferAddr])
         errQ <= 1'b1;
   end

   assign wr_en        = wrEnQ;
   assign wr_addr      = wrAddrQ;
   assign wr_data      = wrDataQ;
   assign busy_vec     = busyQ;
   assign err_spurious = errQ;

`ifdef WB_FORWARD_EN
   assign fwd1 = wrEnQ & (iss_src1 == wrAddrQ);
   assign fwd2 = wrEnQ & (iss_src2 == wrAddrQ);
`endif

endmodule

// File: tb/tb_wb_scoreboard_ctrl.sv
// Directed bench for wb_scoreboard_ctrl; honours WB_FORWARD_EN for forwarding timing.
module tb_wb_scoreboard_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid, iss_has_dest, iss_stall;
   logic [3:0]  iss_src1, iss_src2, iss_dest;
   logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
   logic [3:0]  wb0_addr, wb1_addr, wr_addr;
   logic [15:0] wb0_data, wb1_data, wr_data, busy_vec;
   logic        wr_en, err_spurious;
`ifdef WB_FORWARD_EN
   logic        fwd1, fwd2;
`endif
   int nVec = 0;
   int nErr = 0;

   always #5 clk = ~clk;

   wb_scoreboard_ctrl dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_src1(iss_src1), .iss_src2(iss_src2),
      .iss_has_dest(iss_has_dest), .iss_dest(iss_dest), .iss_stall(iss_stall),
      .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_vec(busy_vec),
`ifdef WB_FORWARD_EN
      .fwd1(fwd1), .fwd2(fwd2),
`endif
      .err_spurious(err_spurious)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iss_valid = 0; iss_has_dest = 0; iss_src1 = 0; iss_src2 = 0; iss_dest = 0;
      wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
      wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 0;
      #2;
      rst = 1;
      #1;
   endtask

   task automatic issue_dest(input logic [3:0] d);
      iss_valid = 1; iss_has_dest = 1; iss_src1 = 0; iss_src2 = 0; iss_dest = d;
      step();
      iss_valid = 0; iss_has_dest = 0;
   endtask

   task automatic test_reset();
      nVec++; if (busy_vec !== 16'h0 || wr_en !== 1'b0 || wr_addr !== 4'h0 || wr_data !== 16'h0 || err_spurious !== 1'b0) begin
         nErr++; $display("FAIL reset_state: got busy=%h wr_en=%b addr=%h data=%h err=%b, expected all zero", busy_vec, wr_en, wr_addr, wr_data, err_spurious);
      end
      rst = 1;
      #1;
      nVec++; if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0 || iss_stall !== 1'b0) begin
         nErr++; $display("FAIL idle_outputs: got rdy0=%b rdy1=%b stall=%b, expected 0 0 0", wb0_ready, wb1_ready, iss_stall);
      end
      step();
      issue_dest(4'd4); issue_dest(4'd5); issue_dest(4'd6); issue_dest(4'd7);
      wb1_valid = 1; wb1_addr = 4'd9; wb1_data = 16'h1234;
      step();
      wb1_valid = 0;
      nVec++; if (busy_vec !== 16'h00F0 || wr_en !== 1'b1 || wr_addr !== 4'd9) begin
         nErr++; $display("FAIL pre_reset: got busy=%h wr_en=%b addr=%h, expected 00f0 1 9", busy_vec, wr_en, wr_addr);
      end
      @(negedge clk);
      rst = 0;
      #1;
      nVec++; if (busy_vec !== 16'h0 || wr_en !== 1'b0 || wr_addr !== 4'h0 || wr_data !== 16'h0 || err_spurious !== 1'b0) begin
         nErr++; $display("FAIL async_reset: got busy=%h wr_en=%b addr=%h data=%h err=%b, expected all zero", busy_vec, wr_en, wr_addr, wr_data, err_spurious);
      end
      step();
      rst = 1;
   endtask

   task automatic test_raw();
      do_reset();
      issue_dest(4'd3);
      iss_valid = 1; iss_has_dest = 0; iss_src1 = 4'd3; iss_src2 = 4'd0;
      #1;
      nVec++; if (iss_stall !== 1'b1) begin
         nErr++; $display("FAIL raw_stall: got %b expected 1", iss_stall);
      end
      step();
      wb0_valid = 1; wb0_addr = 4'd3; wb0_data = 16'hBEEF;
      #1;
      nVec++; if (wb0_ready !== 1'b1 || iss_stall !== 1'b1) begin
         nErr++; $display("FAIL raw_xfer: got rdy0=%b stall=%b expected 1 1", wb0_ready, iss_stall);
      end
      step();
      wb0_valid = 0;
      #1;
      nVec++; if (wr_en !== 1'b1 || wr_addr !== 4'd3 || wr_data !== 16'hBEEF) begin
         nErr++; $display("FAIL raw_write: got en=%b addr=%h data=%h expected 1 3 beef", wr_en, wr_addr, wr_data);
      end
`ifdef WB_FORWARD_EN
      nVec++; if (iss_stall !== 1'b0 || fwd1 !== 1'b1 || fwd2 !== 1'b0) begin
         nErr++; $display("FAIL raw_fwd: got stall=%b fwd1=%b fwd2=%b expected 0 1 0", iss_stall, fwd1, fwd2);
      end
`else
      nVec++; if (iss_stall !== 1'b1) begin
         nErr++; $display("FAIL raw_n1_stall: got %b expected 1", iss_stall);
      end
`endif
      step();
      nVec++; if (iss_stall !== 1'b0 || wr_en !== 1'b0 || busy_vec !== 16'h0) begin
         nErr++; $display("FAIL raw_n2: got stall=%b en=%b busy=%h expected 0 0 0000", iss_stall, wr_en, busy_vec);
      end
      idle();
   endtask

   task automatic test_contention();
      do_reset();
      issue_dest(4'd1); issue_dest(4'd2); issue_dest(4'd3); issue_dest(4'd4);
      nVec++; if (busy_vec !== 16'h001E) begin
         nErr++; $display("FAIL cont_busy: got %h expected 001e", busy_vec);
      end
      wb0_valid = 1; wb0_addr = 4'd1; wb0_data = 16'hA001;
      wb1_valid = 1; wb1_addr = 4'd2; wb1_data = 16'hB002;
      for (int k = 0; k < 4; k++) begin
         #1;
         nVec++; if ({wb1_ready, wb0_ready} !== (((k % 2) == 0) ? 2'b01 : 2'b10)) begin
            nErr++; $display("FAIL cont_grant%0d: got %b%b", k, wb1_ready, wb0_ready);
         end
         if (k > 0) begin
            nVec++; if (wr_en !== 1'b1 || wr_addr !== k[3:0]) begin
               nErr++; $display("FAIL cont_wr%0d: got en=%b addr=%h expected 1 %0d", k, wr_en, wr_addr, k);
            end
         end
         step();
         case (k)
            0: begin wb0_addr = 4'd3; wb0_data = 16'hA003; end
            1: begin wb1_addr = 4'd4; wb1_data = 16'hB004; end
            2: wb0_valid = 0;
            default: wb1_valid = 0;
         endcase
      end
      #1;
      nVec++; if (wr_en !== 1'b1 || wr_addr !== 4'd4 || wr_data !== 16'hB004 || busy_vec !== 16'h0010) begin
         nErr++; $display("FAIL cont_last: got en=%b addr=%h data=%h busy=%h expected 1 4 b004 0010", wr_en, wr_addr, wr_data, busy_vec);
      end
      step();
      nVec++; if (wr_en !== 1'b0 || busy_vec !== 16'h0) begin
         nErr++; $display("FAIL cont_done: got en=%b busy=%h expected 0 0000", wr_en, busy_vec);
      end
   endtask

   task automatic test_waw();
      do_reset();
      issue_dest(4'd5);
      iss_valid = 1; iss_has_dest = 1; iss_dest = 4'd5; iss_src1 = 0; iss_src2 = 0;
      #1;
      nVec++; if (iss_stall !== 1'b1) begin
         nErr++; $display("FAIL waw_stall: got %b expected 1", iss_stall);
      end
      wb0_valid = 1; wb0_addr = 4'd5; wb0_data = 16'h0055;
      step();
      wb0_valid = 0;
      #1;
`ifdef WB_FORWARD_EN
      nVec++; if (iss_stall !== 1'b0) begin
         nErr++; $display("FAIL waw_n1: got stall=%b expected 0", iss_stall);
      end
`else
      nVec++; if (iss_stall !== 1'b1) begin
         nErr++; $display("FAIL waw_n1: got stall=%b expected 1", iss_stall);
      end
      step();
      nVec++; if (iss_stall !== 1'b0 || busy_vec !== 16'h0) begin
         nErr++; $display("FAIL waw_n2: got stall=%b busy=%h expected 0 0000", iss_stall, busy_vec);
      end
`endif
      step();
      idle();
      nVec++; if (busy_vec !== 16'h0020) begin
         nErr++; $display("FAIL waw_reset: got busy=%h expected 0020", busy_vec);
      end
   endtask

   task automatic test_spurious();
      do_reset();
      wb1_valid = 1; wb1_addr = 4'd9; wb1_data = 16'h5A5A;
      #1;
      nVec++; if (wb1_ready !== 1'b1 || wb0_ready !== 1'b0) begin
         nErr++; $display("FAIL spur_grant: got rdy1=%b rdy0=%b expected 1 0", wb1_ready, wb0_ready);
      end
      step();
      wb1_valid = 0;
      nVec++; if (wr_en !== 1'b1 || wr_addr !== 4'd9 || wr_data !== 16'h5A5A || err_spurious !== 1'b1) begin
         nErr++; $display("FAIL spur_write: got en=%b addr=%h data=%h err=%b expected 1 9 5a5a 1", wr_en, wr_addr, wr_data, err_spurious);
      end
      step(); step();
      nVec++; if (wr_en !== 1'b0 || err_spurious !== 1'b1) begin
         nErr++; $display("FAIL spur_sticky: got en=%b err=%b expected 0 1", wr_en, err_spurious);
      end
   endtask

`ifdef WB_FORWARD_EN
   task automatic test_same_edge();
      do_reset();
      issue_dest(4'd2);
      wb0_valid = 1; wb0_addr = 4'd2; wb0_data = 16'h0002;
      step();
      wb0_valid = 0;
      iss_valid = 1; iss_has_dest = 1; iss_dest = 4'd2;
      #1;
      nVec++; if (iss_stall !== 1'b0 || wr_en !== 1'b1) begin
         nErr++; $display("FAIL same_edge_issue: got stall=%b en=%b expected 0 1", iss_stall, wr_en);
      end
      step();
      idle();
      nVec++; if (busy_vec !== 16'h0004) begin
         nErr++; $display("FAIL same_edge_busy: got %h expected 0004", busy_vec);
      end
   endtask
`endif

   initial begin
      idle();
      rst = 0;
      step(); step();
      test_reset();
      test_raw();
      test_contention();
      test_waw();
      test_spurious();
`ifdef WB_FORWARD_EN
      test_same_edge();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
